// File: rtl/pardcore_rst_ctrl_if.sv
// pardcore_rst_ctrl_if
//   Groups the soft-reset request handshake and the memory-path quiesce
//   handshake of the pardcore reset sequencer.
//
//   sw_req_valid  requester -> ctrl  soft-reset request valid
//   sw_req_ready  ctrl -> requester  request can be accepted
//   sw_req_mask   requester -> ctrl  cores to reset, sampled on handshake
//   quiesce_req   ctrl -> mem path   stop issuing and drain
//   quiesce_ack   mem path -> ctrl   drained (level, may be high early)
//
//   master: requester / memory-path side; slave: reset controller side.
interface pardcore_rst_ctrl_if #(
  parameter int NCORE = 2
);
  logic             sw_req_valid;
  logic             sw_req_ready;
  logic [NCORE-1:0] sw_req_mask;
  logic             quiesce_req;
  logic             quiesce_ack;

  modport master (
    output sw_req_valid,
    output sw_req_mask,
    input  sw_req_ready,
    input  quiesce_req,
    output quiesce_ack
  );

  modport slave (
    input  sw_req_valid,
    input  sw_req_mask,
    output sw_req_ready,
    output quiesce_req,
    input  quiesce_ack
  );
endinterface

// File: rtl/pardcore_rst_ctrl.sv
// pardcore_rst_ctrl
//   Reset sequencer for the pardcore subsystem. Synchronizes the raw reset,
//   releases uncore reset and then each core reset in a staggered order, and
//   afterwards serves software soft-reset requests for any subset of cores,
//   draining the memory path through a quiesce handshake first.
//
//   Ports:
//     coreclk       in   sole clock
//     corersts      in   raw reset, asynchronous, active-high
//     bus           slave modport of pardcore_rst_ctrl_if (request + quiesce)
//     uncore_rst    out  uncore reset, active-high
//     core_rst      out  per-core resets, active-high
//     jtag_trst     out  debug TRST, always equal to core_rst[0]
//     busy          out  high in every state except RUN
//     timeout_flag  out  sticky drain-timeout indicator
//
//   Optional feature: define RST_TIMEOUT_EN to bound the DRAIN wait by
//   TIMEOUT cycles; without it DRAIN waits forever and timeout_flag is 0.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   BOOT_HOLD  | everything in reset, counting HOLD_CYCLES
//   BOOT_REL   | releasing cores one per STAGGER cycles, ascending
//   RUN        | idle, accepting soft-reset requests
//   DRAIN      | quiesce_req high, waiting for quiesce_ack
//   ASSERT     | masked cores held in reset for HOLD_CYCLES
//   RELEASE    | releasing masked cores one per STAGGER cycles, ascending
module pardcore_rst_ctrl #(
  parameter int NCORE       = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic                  coreclk,
  input  logic                  corersts,
  pardcore_rst_ctrl_if.slave    bus,
  output logic                  uncore_rst,
  output logic [NCORE-1:0]      core_rst,
  output logic                  jtag_trst,
  output logic                  busy,
  output logic                  timeout_flag
);

  localparam int MAX_HS  = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int MAX_ALL = (MAX_HS > TIMEOUT) ? MAX_HS : TIMEOUT;
  localparam int CW      = $clog2(MAX_ALL + 1);

  typedef enum logic [2:0] {
    S_BOOT_HOLD,
    S_BOOT_REL,
    S_RUN,
    S_DRAIN,
    S_ASSERT,
    S_RELEASE
  } state_t;

  // Reset synchronizer: asserts immediately, deasserts after two edges.
  logic [1:0] rst_sync;
  logic       rst_s;

  always_ff @(posedge coreclk or posedge corersts) begin
    if (corersts) rst_sync <= 2'b11;
    else          rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst_s = rst_sync[1];

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  // Cores still waiting to be released (or the latched request mask
  // before ASSERT), consumed lowest bit first.
  logic [NCORE-1:0] pend, pend_nxt;
  logic [NCORE-1:0] pend_lsb;
  logic             uncore_nxt;
  logic [NCORE-1:0] core_nxt;
  logic             qreq_q, qreq_nxt;
  logic             flag_q, flag_nxt;

  assign pend_lsb = pend & (~pend + NCORE'(1));

  always_ff @(posedge coreclk or posedge rst_s) begin
    if (rst_s) begin
      state      <= S_BOOT_HOLD;
      cnt        <= '0;
      pend       <= '0;
      uncore_rst <= 1'b1;
      core_rst   <= '1;
      qreq_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pend       <= pend_nxt;
      uncore_rst <= uncore_nxt;
      core_rst   <= core_nxt;
      qreq_q     <= qreq_nxt;
    end
  end

`ifdef RST_TIMEOUT_EN
  always_ff @(posedge coreclk or posedge rst_s) begin
    if (rst_s) flag_q <= 1'b0;
    else       flag_q <= flag_nxt;
  end
`else
  assign flag_q = 1'b0;
`endif

  // The counter defaults to 0 so that every state entry (and every single
  // release inside the staggered states) restarts it.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = '0;
    pend_nxt   = pend;
    uncore_nxt = uncore_rst;
    core_nxt   = core_rst;
    qreq_nxt   = qreq_q;
    flag_nxt   = flag_q;
    case (state)
      S_BOOT_HOLD: begin
        if (cnt == CW'(HOLD_CYCLES - 1)) begin
          uncore_nxt = 1'b0;
          pend_nxt   = '1;
          state_nxt  = S_BOOT_REL;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_BOOT_REL, S_RELEASE: begin
        // One idle cycle after the last release before returning to RUN.
        if (pend == '0) begin
          qreq_nxt  = 1'b0;
          state_nxt = S_RUN;
        end else if (cnt == CW'(STAGGER - 1)) begin
          core_nxt = core_rst & ~pend_lsb;
          pend_nxt = pend & ~pend_lsb;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (bus.sw_req_valid) begin
          flag_nxt = 1'b0;
          if (bus.sw_req_mask != '0) begin
            pend_nxt  = bus.sw_req_mask;
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        qreq_nxt = 1'b1;
        if (bus.quiesce_ack) begin
          state_nxt = S_ASSERT;
        end
`ifdef RST_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          flag_nxt  = 1'b1;
          state_nxt = S_ASSERT;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
`endif
      end
      S_ASSERT: begin
        if (cnt == '0) core_nxt = core_rst | pend;
        // The first masked release happens on the exit edge, so RELEASE
        // only has to pace the remaining ones.
        if (cnt == CW'(HOLD_CYCLES)) begin
          core_nxt  = core_rst & ~pend_lsb;
          pend_nxt  = pend & ~pend_lsb;
          state_nxt = S_RELEASE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = S_BOOT_HOLD;
    endcase
  end

  assign bus.sw_req_ready = (state == S_RUN);
  assign bus.quiesce_req  = qreq_q;
  assign busy             = (state != S_RUN);
  assign jtag_trst        = core_rst[0];
  assign timeout_flag     = flag_q;

endmodule
